// File: rtl/sub_bytes_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_seq_if
// Brief    : Block-level valid/ready handshake bundle for the iterative
//            SubBytes stage (input side and output side in one interface).
// Revision : 1.0 - initial release
// ============================================================================
interface sub_bytes_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   // Upstream/downstream side: drives blocks in and consumes results.
   modport master (
      output in_valid,
      output in_state,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_state
   );

   // Stage side: accepts blocks and presents substituted results.
   modport slave (
      input  in_valid,
      input  in_state,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_state
   );
endinterface
`default_nettype wire

// File: rtl/sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_seq
// Brief    : Iterative AES SubBytes. A 128-bit state is loaded, then LANES
//            bytes per clock are replaced through LANES shared S-boxes, MSB
//            chunk first, and the result is presented with valid/ready.
//            LANES must be one of 1, 2, 4, 8, 16.
// Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_seq #(
   parameter int LANES   = 4,
   parameter bit INVERSE = 1'b0
) (
   input  wire            clk,
   input  wire            rst_n,
   input  wire            clear,
   sub_bytes_seq_if.slave bus,
   output logic           busy
);

   localparam int c_NCYC    = 16 / LANES;
   localparam int c_CNT_W   = (c_NCYC > 1) ? $clog2(c_NCYC) : 1;
   localparam int c_CHUNK_W = 8 * LANES;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NCYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [127:0]         r_data;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;

   logic [c_CHUNK_W-1:0] w_chunk;
   logic [c_CHUNK_W-1:0] w_sub;
   logic [127:0]         w_next;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   // Forward affine map: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
   function automatic logic [7:0] fwd_affine(input logic [7:0] x);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
               ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
   function automatic logic [7:0] inv_affine(input logic [7:0] x);
      return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
   endfunction

   // One S-box lookup, computed algebraically instead of a ROM table.
   function automatic logic [7:0] sbox_byte(input logic [7:0] x);
      if (INVERSE) return gf_inv(inv_affine(x));
      else         return fwd_affine(gf_inv(x));
   endfunction

   // Pick the chunk addressed by the iteration counter (chunk 0 = MSBs).
   always_comb begin
      w_chunk = '0;
      for (int k = 0; k < c_NCYC; k++) begin
         if (r_cnt == k[c_CNT_W-1:0]) w_chunk = r_data[127 - c_CHUNK_W*k -: c_CHUNK_W];
      end
   end

   // Independent byte lanes; byte order inside the chunk is preserved.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_sub[c_CHUNK_W-1-8*l -: 8] = sbox_byte(w_chunk[c_CHUNK_W-1-8*l -: 8]);
   end

   // Write the substituted chunk back in place, leaving all other bytes.
   always_comb begin
      w_next = r_data;
      for (int k = 0; k < c_NCYC; k++) begin
         if (r_cnt == k[c_CNT_W-1:0]) w_next[127 - c_CHUNK_W*k -: c_CHUNK_W] = w_sub;
      end
   end

   // Control FSM with registered handshake/status outputs; clear aborts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_data      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (clear) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_data      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // in_ready is always high here, so in_valid alone completes the handshake.
               if (bus.in_valid) begin
                  r_data     <= bus.in_state;
                  r_cnt      <= '0;
                  r_state    <= ST_RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            ST_RUN: begin
               r_data <= w_next;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               // r_data is left alone so out_state holds until the next load.
               if (bus.out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cnt       <= '0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_state = r_data;
   assign busy          = r_busy;

endmodule
`default_nettype wire
